// File: rtl/rbb_pingpong.sv
`default_nettype none
// ============================================================================
// Module      : rbb_pingpong
// Description : Double-buffered result batch buffer. The PE side packs narrow
//               words into wide lines of a fill bank. The drain side streams
//               completed banks to the host over a valid/ack interface.
//               Optional performance counters are enabled with the macro
//               RBB_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rbb_pingpong #(
    parameter int RD_ADDR_WIDTH = 8,
    parameter int RD_DATA_WIDTH = 512,
    parameter int WR_DATA_WIDTH = 32,
    parameter int WR_ADDR_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     WrEn,
    input  logic [WR_ADDR_WIDTH-1:0] WrAddr,
    input  logic [WR_DATA_WIDTH-1:0] WrDin,
    input  logic                     task_done,
    input  logic [RD_ADDR_WIDTH-1:0] task_lines,
    output logic                     ReqValid,
    output logic [RD_ADDR_WIDTH-1:0] ReqLineIdx,
    output logic                     ReqBank,
    output logic [RD_DATA_WIDTH-1:0] RdDout,
    input  logic                     ReqAck,
    output logic                     Full,
    output logic                     Empty,
    output logic                     WrBank,
    output logic                     Overflow,
    output logic                     TestCmp,
    output logic [15:0]              BatchCnt,
    output logic [31:0]              StallCnt
);

    localparam int R         = RD_DATA_WIDTH / WR_DATA_WIDTH;
    localparam int LW        = $clog2(R);
    localparam int NUM_LINES = 1 << RD_ADDR_WIDTH;
    localparam int DEPTH     = 2 * NUM_LINES;

    generate
        if ((R < 2) || ((1 << LW) != R) || (R * WR_DATA_WIDTH != RD_DATA_WIDTH)) begin : g_bad_ratio
            $error("rbb_pingpong: RD_DATA_WIDTH/WR_DATA_WIDTH must be a power of two >= 2");
        end
        if (WR_ADDR_WIDTH != RD_ADDR_WIDTH + LW) begin : g_bad_addr
            $error("rbb_pingpong: WR_ADDR_WIDTH must equal RD_ADDR_WIDTH + log2(ratio)");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic                            wr_bank_q, wr_bank_d;
    logic                            rd_bank_q, rd_bank_d;
    logic [1:0]                      bank_full_q, bank_full_d;
    logic [1:0][RD_ADDR_WIDTH-1:0]   lines_q, lines_d;
    logic                            set_pend_q, set_pend_d;
    logic                            set_bank_q, set_bank_d;
    logic [RD_DATA_WIDTH-1:0]        asm_q, asm_d;
    logic                            commit_q, commit_d;
    logic [RD_ADDR_WIDTH:0]          commit_addr_q, commit_addr_d;
    logic [RD_ADDR_WIDTH-1:0]        idx_q, idx_d;
    logic                            overflow_q, overflow_d;
    logic                            test_cmp_q, test_cmp_d;
    logic [RD_DATA_WIDTH-1:0]        rdata_q;

    logic [RD_DATA_WIDTH-1:0]        mem [DEPTH];

    logic [LW-1:0]                   wr_lane;
    logic [RD_ADDR_WIDTH-1:0]        wr_line;
    logic                            fill_full;
    logic                            wr_accept;
    logic                            done_accept;
    logic                            drain_done;
    logic [RD_ADDR_WIDTH-1:0]        last_idx;
    logic [RD_ADDR_WIDTH:0]          raddr;
    logic                            rd_en;

    assign wr_lane     = WrAddr[LW-1:0];
    assign wr_line     = WrAddr[WR_ADDR_WIDTH-1:LW];
    assign fill_full   = bank_full_q[wr_bank_q];
    assign wr_accept   = WrEn & ~fill_full;
    assign done_accept = task_done & ~fill_full;
    assign last_idx    = lines_q[rd_bank_q] - RD_ADDR_WIDTH'(1);

    // Fill side: lane packing, line commit and bank hand-over
    always_comb begin
        asm_d = asm_q;
        for (int k = 0; k < R; k++) begin
            if (wr_accept && (wr_lane == LW'(k))) begin
                asm_d[(R-1-k)*WR_DATA_WIDTH +: WR_DATA_WIDTH] = WrDin;
            end
        end
        commit_d      = wr_accept & (&wr_lane);
        commit_addr_d = {wr_bank_q, wr_line};
        wr_bank_d     = wr_bank_q ^ done_accept;
        set_pend_d    = done_accept;
        set_bank_d    = wr_bank_q;
        lines_d       = lines_q;
        if (done_accept) begin
            lines_d[wr_bank_q] = task_lines;
        end
        overflow_d = overflow_q | ((WrEn | task_done) & fill_full);
    end

    // Drain side: line sequencing and bank release
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_bank_d  = rd_bank_q;
        test_cmp_d = test_cmp_q;
        drain_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d = S_SEND;
                    idx_d   = '0;
                end
            end
            S_SEND: begin
                if (ReqAck) begin
                    if (idx_q == last_idx) begin
                        drain_done = 1'b1;
                        state_d    = S_IDLE;
                        idx_d      = '0;
                        rd_bank_d  = ~rd_bank_q;
                        test_cmp_d = 1'b1;
                    end else begin
                        idx_d = idx_q + RD_ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // The full flag lags task_done by a cycle so the final committed line lands first
    always_comb begin
        bank_full_d = bank_full_q;
        if (set_pend_q) begin
            bank_full_d[set_bank_q] = 1'b1;
        end
        if (drain_done) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
    end

    assign raddr = {rd_bank_d, idx_d};
    assign rd_en = (state_d == S_SEND);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            bank_full_q   <= 2'b00;
            lines_q       <= '0;
            set_pend_q    <= 1'b0;
            set_bank_q    <= 1'b0;
            asm_q         <= '0;
            commit_q      <= 1'b0;
            commit_addr_q <= '0;
            idx_q         <= '0;
            overflow_q    <= 1'b0;
            test_cmp_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            bank_full_q   <= bank_full_d;
            lines_q       <= lines_d;
            set_pend_q    <= set_pend_d;
            set_bank_q    <= set_bank_d;
            asm_q         <= asm_d;
            commit_q      <= commit_d;
            commit_addr_q <= commit_addr_d;
            idx_q         <= idx_d;
            overflow_q    <= overflow_d;
            test_cmp_q    <= test_cmp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (commit_q) begin
            mem[commit_addr_q] <= asm_q;
        end
    end

    // Read port only advances while a line is being offered, so idle output stays put
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= mem[raddr];
        end
    end

    assign ReqValid   = (state_q == S_SEND);
    assign ReqLineIdx = idx_q;
    assign ReqBank    = rd_bank_q;
    assign RdDout     = rdata_q;
    assign Full       = &bank_full_q;
    assign Empty      = ~|bank_full_q;
    assign WrBank     = wr_bank_q;
    assign Overflow   = overflow_q;
    assign TestCmp    = test_cmp_q;

`ifdef RBB_PERF_CNT_EN
    logic [15:0] batch_cnt_q, batch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        batch_cnt_d = batch_cnt_q + {15'd0, drain_done};
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_SEND) && !ReqAck && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            batch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            batch_cnt_q <= batch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign BatchCnt = batch_cnt_q;
    assign StallCnt = stall_cnt_q;
`else
    assign BatchCnt = '0;
    assign StallCnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rbb_pingpong.sv
`default_nettype none
// ============================================================================
// Module      : tb_rbb_pingpong
// Description : Scoreboard bench for rbb_pingpong; directed fill/drain batches.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rbb_pingpong;

    localparam int AW  = 8;
    localparam int DW  = 512;
    localparam int WW  = 32;
    localparam int WAW = 12;
    localparam int R   = 16;
    localparam int NL  = 256;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           WrEn = 1'b0;
    logic [WAW-1:0] WrAddr = '0;
    logic [WW-1:0]  WrDin = '0;
    logic           task_done = 1'b0;
    logic [AW-1:0]  task_lines = '0;
    logic           ReqAck = 1'b0;
    logic           ReqValid;
    logic [AW-1:0]  ReqLineIdx;
    logic           ReqBank;
    logic [DW-1:0]  RdDout;
    logic           Full, Empty, WrBank, Overflow, TestCmp;
    logic [15:0]    BatchCnt;
    logic [31:0]    StallCnt;

    always #5 clk = ~clk;

    rbb_pingpong dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .WrEn       (WrEn),
        .WrAddr     (WrAddr),
        .WrDin      (WrDin),
        .task_done  (task_done),
        .task_lines (task_lines),
        .ReqValid   (ReqValid),
        .ReqLineIdx (ReqLineIdx),
        .ReqBank    (ReqBank),
        .RdDout     (RdDout),
        .ReqAck     (ReqAck),
        .Full       (Full),
        .Empty      (Empty),
        .WrBank     (WrBank),
        .Overflow   (Overflow),
        .TestCmp    (TestCmp),
        .BatchCnt   (BatchCnt),
        .StallCnt   (StallCnt)
    );

    typedef struct {
        logic          bank;
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model [2][NL];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            ack_mode = 0;
    int            stall_seen = 0;
    int            last_done_cyc = -100;
    bit            expect_b2b = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    // Ack driver: 0 = held low, 1 = held high, 2 = toggles every cycle
    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0:       ReqAck = 1'b0;
            1:       ReqAck = 1'b1;
            default: ReqAck = ~ReqAck;
        endcase
    end

    // Monitor: handshakes pop the scoreboard; stalled offers must hold steady
    logic          prev_vld = 1'b0;
    logic          prev_ack = 1'b0;
    logic          prev_bank = 1'b0;
    logic [AW-1:0] prev_idx = '0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        exp_t e;
        if (ReqValid && !ReqAck) stall_seen++;
        if (prev_vld && !prev_ack) begin
            chk("hold_valid", 64'(ReqValid), 64'd1);
            if (ReqValid) begin
                chk("hold_idx", 64'(ReqLineIdx), 64'(prev_idx));
                chk("hold_bank", 64'(ReqBank), 64'(prev_bank));
                chk_data("hold_data", RdDout, prev_data);
            end
        end
        if (ReqValid && !prev_vld && expect_b2b) begin
            chk("b2b_gap", 64'(cyc - last_done_cyc), 64'd2);
            expect_b2b = 1'b0;
        end
        if (ReqValid && ReqAck) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_line: got bank=%0d idx=%0d expected no line", ReqBank, ReqLineIdx);
            end else begin
                e = exp_q.pop_front();
                chk("line_bank", 64'(ReqBank), 64'(e.bank));
                chk("line_idx", 64'(ReqLineIdx), 64'(e.idx));
                chk_data("line_data", RdDout, e.data);
                if (e.last) last_done_cyc = cyc;
            end
        end
        prev_vld  = ReqValid;
        prev_ack  = ReqAck;
        prev_bank = ReqBank;
        prev_idx  = ReqLineIdx;
        prev_data = RdDout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        reset_n = 1'b1;
        stall_seen = 0;
    endtask

    task automatic fill(input bit b, input int nlines, input logic [31:0] base,
                        input bit done_last, input logic [AW-1:0] tl);
        for (int l = 0; l < nlines; l++) begin
            for (int k = 0; k < R; k++) begin
                logic [31:0] v;
                v = base + 32'(l * R + k);
                WrEn   = 1'b1;
                WrAddr = WAW'(l * R + k);
                WrDin  = v;
                model[b][l][(R-1-k)*WW +: WW] = v;
                if (done_last && (l == nlines - 1) && (k == R - 1)) begin
                    task_done  = 1'b1;
                    task_lines = tl;
                end
                tick();
            end
        end
        WrEn      = 1'b0;
        task_done = 1'b0;
    endtask

    task automatic pulse_done(input logic [AW-1:0] tl);
        task_done  = 1'b1;
        task_lines = tl;
        tick();
        task_done  = 1'b0;
    endtask

    task automatic push_batch(input bit b, input int n, input int upto);
        for (int i = 0; i < upto; i++) begin
            exp_t e;
            e.bank = b;
            e.idx  = AW'(i);
            e.data = model[b][i];
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d lines left expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int n;

        // Reset state
        do_reset();
        chk("rst_valid", 64'(ReqValid), 64'd0);
        chk("rst_idx", 64'(ReqLineIdx), 64'd0);
        chk("rst_bank", 64'(ReqBank), 64'd0);
        chk_data("rst_dout", RdDout, '0);
        chk("rst_full", 64'(Full), 64'd0);
        chk("rst_empty", 64'(Empty), 64'd1);
        chk("rst_wrbank", 64'(WrBank), 64'd0);
        chk("rst_ovf", 64'(Overflow), 64'd0);
        chk("rst_cmp", 64'(TestCmp), 64'd0);
        chk("rst_batch", 64'(BatchCnt), 64'd0);
        chk("rst_stall", 64'(StallCnt), 64'd0);

        // Three-line batch from bank 0
        ack_mode = 1;
        fill(1'b0, 3, 32'hA000_0000, 1'b0, '0);
        pulse_done(8'd3);
        push_batch(1'b0, 3, 3);
        chk("t3_wrbank", 64'(WrBank), 64'd1);
        chk("t3_cmp_early", 64'(TestCmp), 64'd0);
        wait_drain("t3");
        chk("t3_cmp", 64'(TestCmp), 64'd1);
        chk("t3_empty", 64'(Empty), 64'd1);
        chk("t3_valid", 64'(ReqValid), 64'd0);

        // Full 256-line batch in bank 1, word value = word address
        fill(1'b1, NL, 32'd0, 1'b0, '0);
        pulse_done(8'd0);
        push_batch(1'b1, NL, NL);
        wait_drain("full");
        chk("full_cmp", 64'(TestCmp), 64'd1);
        chk("full_empty", 64'(Empty), 64'd1);
        chk("full_valid", 64'(ReqValid), 64'd0);
        chk("full_wrbank", 64'(WrBank), 64'd0);
        chk_data("full_line5_model", model[1][5],
                 {32'd80, 32'd81, 32'd82, 32'd83, 32'd84, 32'd85, 32'd86, 32'd87,
                  32'd88, 32'd89, 32'd90, 32'd91, 32'd92, 32'd93, 32'd94, 32'd95});

        // Ping-pong: bank 1 filled while bank 0 drains with toggling ack
        do_reset();
        ack_mode = 2;
        fill(1'b0, 32, 32'hB000_0000, 1'b0, '0);
        pulse_done(8'd32);
        push_batch(1'b0, 32, 32);
        fill(1'b1, 2, 32'hB100_0000, 1'b0, '0);
        pulse_done(8'd2);
        push_batch(1'b1, 2, 2);
        expect_b2b = 1'b1;
        wait_drain("pp");
        chk("pp_b2b_seen", 64'(expect_b2b), 64'd0);
        chk("pp_empty", 64'(Empty), 64'd1);
`ifdef RBB_PERF_CNT_EN
        chk("pp_batch", 64'(BatchCnt), 64'd2);
        chk("pp_stall", 64'(StallCnt), 64'(stall_seen));
`else
        chk("pp_batch", 64'(BatchCnt), 64'd0);
        chk("pp_stall", 64'(StallCnt), 64'd0);
`endif

        // Overflow: both banks pending, dropped write and ignored task_done
        ack_mode = 0;
        fill(1'b0, 1, 32'hC000_0000, 1'b0, '0);
        pulse_done(8'd1);
        push_batch(1'b0, 1, 1);
        fill(1'b1, 1, 32'hD000_0000, 1'b0, '0);
        pulse_done(8'd1);
        push_batch(1'b1, 1, 1);
        repeat (2) tick();
        chk("ovf_full", 64'(Full), 64'd1);
        chk("ovf_empty", 64'(Empty), 64'd0);
        chk("ovf_pre", 64'(Overflow), 64'd0);
        chk("ovf_wrbank", 64'(WrBank), 64'd0);
        WrEn   = 1'b1;
        WrAddr = 12'd15;
        WrDin  = 32'hFFFF_FFFF;
        tick();
        WrEn = 1'b0;
        tick();
        chk("ovf_wr", 64'(Overflow), 64'd1);
        pulse_done(8'd1);
        tick();
        chk("ovf_done_wrbank", 64'(WrBank), 64'd0);
        chk("ovf_done_full", 64'(Full), 64'd1);
        ack_mode = 1;
        wait_drain("ovf");
        chk("ovf_after_empty", 64'(Empty), 64'd1);
        chk("ovf_sticky", 64'(Overflow), 64'd1);

        // Last word of the line coincides with task_done
        fill(1'b0, 1, 32'hE000_0000, 1'b1, 8'd1);
        push_batch(1'b0, 1, 1);
        wait_drain("last");

        // Reset while offering line 5
        fill(1'b1, 8, 32'hF000_0000, 1'b0, '0);
        pulse_done(8'd8);
        push_batch(1'b1, 8, 6);
        found = 1'b0;
        n = 0;
        while (n < 200 && !found) begin
            @(negedge clk);
            n++;
            if (ReqValid && ReqLineIdx == 8'd5) found = 1'b1;
        end
        chk("rst5_found", 64'(found), 64'd1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst5_valid", 64'(ReqValid), 64'd0);
        chk("rst5_empty", 64'(Empty), 64'd1);
        chk("rst5_ovf", 64'(Overflow), 64'd0);
        chk("rst5_cmp", 64'(TestCmp), 64'd0);
        chk("rst5_lines", 64'(exp_q.size()), 64'd0);
        tick();
        do_reset();

        // Fresh batch after reset
        fill(1'b0, 2, 32'h1234_0000, 1'b0, '0);
        pulse_done(8'd2);
        push_batch(1'b0, 2, 2);
        wait_drain("post");
        chk("post_cmp", 64'(TestCmp), 64'd1);
        chk("post_empty", 64'(Empty), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rbb_pingpong.md
Name: rbb_pingpong

Overview:
- Double-buffered result batch buffer between one PE array and the host write-back arbiter.
- PE side writes narrow result words into a fill bank. Full lines are packed into wide lines.
- On `task_done` the fill bank is handed to the drain side. The drain side streams a runtime-selected number of wide lines through a valid/ack request interface while the PE fills the other bank.
- Generalises the single-bank result buffer: bank count 2, runtime line count, any power-of-two pack ratio, overflow detection.

Parameters:
- `RD_ADDR_WIDTH`, 8: log2 of lines per bank; `NUM_LINES` = 2^`RD_ADDR_WIDTH`.
- `RD_DATA_WIDTH`, 512: wide line width (drain side).
- `WR_DATA_WIDTH`, 32: narrow word width (PE side). `R` = `RD_DATA_WIDTH`/`WR_DATA_WIDTH`; `R` must be a power of two ≥ 2. `LW` = log2(`R`).
- `WR_ADDR_WIDTH`, 12: must equal `RD_ADDR_WIDTH`+`LW`. Any mismatch is an elaboration error.

Ports:
- `clk`  in  1  core clock
- `reset_n`  in  1  synchronous, active-low reset
- `WrEn`  in  1  narrow word write strobe
- `WrAddr`  in  `WR_ADDR_WIDTH`  word address within fill bank; low `LW` bits = lane
- `WrDin`  in  `WR_DATA_WIDTH`  narrow word
- `task_done`  in  1  pulse: current fill bank complete
- `task_lines`  in  `RD_ADDR_WIDTH`  lines to drain, sampled with `task_done`; 0 means `NUM_LINES`
- `ReqValid`  out  1  `RdDout`/`ReqLineIdx`/`ReqBank` valid
- `ReqLineIdx`  out  `RD_ADDR_WIDTH`  line index being offered
- `ReqBank`  out  1  bank being drained
- `RdDout`  out  `RD_DATA_WIDTH`  line data
- `ReqAck`  in  1  line consumed
- `Full`  out  1  both banks awaiting drain
- `Empty`  out  1  no bank awaiting drain
- `WrBank`  out  1  current fill bank
- `Overflow`  out  1  sticky error flag
- `TestCmp`  out  1  sticky: at least one batch fully drained
- `BatchCnt`  out  16  completed drains (optional feature)
- `StallCnt`  out  32  backpressure cycles (optional feature)

Behaviour:
- Reset values: all outputs 0 except `Empty`=1. Also `wr_bank`=0, `rd_bank`=0, `bank_full`=2'b00, drain FSM=IDLE.
- Packing:
  - Each cycle, `WrDin` is written into the assembly register lane k = `WrAddr[LW-1:0]`, at bits [(R-1-k)*W +: W], when `WrEn`=1.
  - When `WrEn`=1 and k=R-1, the line commits one cycle later to RAM address {`wr_bank`, `WrAddr[WR_ADDR_WIDTH-1:LW]`}. The bank is captured in the same cycle as the write.
  - Lanes never written hold stale data; no clearing.
- Write to a bank with `bank_full`=1 is dropped and sets `Overflow`.
- `task_done` when `bank_full[wr_bank]`=0:
  - latch `task_lines` into `lines[wr_bank]`;
  - toggle `wr_bank` immediately;
  - set `bank_full[old bank]` one cycle later, so a final line committed in the same cycle is in RAM before the drain reads it.
- `task_done` when `bank_full[wr_bank]`=1: ignored, sets `Overflow`.
- `Full` = &`bank_full`; `Empty` = ~|`bank_full`; `WrBank` = `wr_bank`.
- RAM:
  - simple dual port, depth 2*`NUM_LINES`, 1-cycle registered read;
  - `raddr` = {bank_next, idx_next} driven combinationally from next-state values.
- Drain FSM states are IDLE and SEND.
  - IDLE → SEND when `bank_full[rd_bank]`. In that cycle `idx_next`=0.
  - SEND: `ReqValid`=1, `ReqBank`=`rd_bank`, `ReqLineIdx`=`idx`, `RdDout`=mem[`rd_bank`,`idx`].
  - SEND, `ReqAck`, `idx` < last: `idx`++. Back-to-back acks give 1 line/cycle.
  - SEND, `ReqAck`, `idx` == last (last = `lines`-1 mod `NUM_LINES`):
    - clear `bank_full[rd_bank]` next edge, toggle `rd_bank`, set `TestCmp`, go IDLE;
    - the next bank starts no earlier than the following cycle.
  - `ReqAck` while `ReqValid`=0 is ignored.
  - Outputs hold stable while `ReqValid`=1 and `ReqAck`=0.
- Simultaneous `task_done` and drain release act on different banks; both take effect.
- Reset mid-operation: every state returns to reset values. RAM contents are undefined and are not read before being refilled.

Optional Feature:
- Macro `RBB_PERF_CNT_EN`.
- Defined:
  - `BatchCnt` increments on each completed drain and wraps at 2^16.
  - `StallCnt` increments each cycle with `ReqValid`=1 and `ReqAck`=0, and saturates at 2^32-1.
  - Both cleared by reset.
- Undefined: both ports are tied to 0 and no counter logic exists.

Test Plan:
- Defaults (`R`=16):
  - Stimulus: write words 0..4095 = address value, `task_done` with `task_lines`=0, `ReqAck` held 1.
  - Response: 256 back-to-back lines. Line n MSB word = 16n, LSB word = 16n+15. `ReqValid` drops after idx 255; `TestCmp`=1; `Empty`=1.
- `task_lines`=3:
  - Response: exactly 3 lines, idx 0,1,2, then bank released and `rd_bank`=1.
- Ping-pong:
  - Stimulus: fill bank 0 and `task_done`; fill bank 1 during drain with `ReqAck` toggling every other cycle; `task_done`.
  - Response: bank 1 drains immediately after bank 0. Data is never corrupted. `StallCnt`=stall cycles, `BatchCnt`=2.
- Overflow:
  - Stimulus: two `task_done` pulses with `ReqAck`=0, then a write and a third `task_done`.
  - Response: `Full`=1, `Overflow`=1. After the drain, bank contents are unchanged.
- Last line plus `task_done` in the same cycle:
  - Response: first drained line reads the new data; no stale read.
- Assert `reset_n`=0 during SEND at idx 5:
  - Response: next cycle `ReqValid`=0, `Empty`=1, `Overflow`=0, `TestCmp`=0.
